pipeline_controller: RTL and testbench

Central stall/flush sequencer for the 16-bit five-stage pipeline. Each cycle it generates the `write_en`/`clear` pair for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the PC write enable. Inputs are load-use hazard information from ID/EX, branch resolution from EX, memory handshake status from MEM, and the `run` bit leaving MEM/WB. It owns halt, memory-wait timeout and a stall-cycle performance counter.

---
 rtl/pipeline_controller.sv | 176 +++++++++++++++++
 tb/tb_pipeline_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the five-stage pipeline: drives the per-stage
// write enables and clears, the PC write enable, halt, memory-wait timeout
// and a saturating stall-cycle counter.
//
// Ports:
//   clk, clear               clock and synchronous active-high reset
//   id_rs/id_rt/id_uses_*    source registers read by the instruction in ID
//   ex_rd, ex_memtoreg       destination and load flag of the instruction in EX
//   ex_branch_taken          taken control transfer resolved in EX
//   mem_access, mem_ready    memory handshake of the instruction in MEM
//   wb_run                   run bit leaving MEM/WB (0 = HALT in WB)
//   pc_write_en, *_write_en  combinational write enables
//   *_clear                  combinational synchronous clears
//   halted, mem_error        registered status flags
//   stall_cycles             registered saturating stall counter
module pipeline_controller #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [3:0]  id_rs,
    input  logic [3:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [3:0]  ex_rd,
    input  logic        ex_memtoreg,
    input  logic        ex_branch_taken,
    input  logic        mem_access,
    input  logic        mem_ready,
    input  logic        wb_run,
    output logic        pc_write_en,
    output logic        if_id_write_en,
    output logic        id_ex_write_en,
    output logic        ex_mem_write_en,
    output logic        mem_wb_write_en,
    output logic        if_id_clear,
    output logic        id_ex_clear,
    output logic        ex_mem_clear,
    output logic        mem_wb_clear,
    output logic        halted,
    output logic        mem_error,
    output logic [15:0] stall_cycles
);

    localparam int unsigned WCNT_W  = 8;
    localparam int unsigned STALL_W = 16;

    typedef enum logic [1:0] {
        S_INIT     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [WCNT_W-1:0]   wcnt;
    logic [WCNT_W-1:0]   wcnt_inc;
    logic                active;
    logic                freeze;
    logic                load_use;
    logic                timeout;
    logic                halt_req;

    // Shared hazard decode for the RUN/MEM_WAIT decision.
    assign active   = (state == S_RUN) || (state == S_MEM_WAIT);
    assign freeze   = mem_access & ~mem_ready;
    assign load_use = ex_memtoreg & ((id_uses_rs & (id_rs == ex_rd)) |
                                     (id_uses_rt & (id_rt == ex_rd)));
    assign wcnt_inc = wcnt + WCNT_W'(1);
    // wcnt_inc is the count this frozen cycle leaves behind.
    assign timeout  = (wcnt_inc == WCNT_W'(MEM_TIMEOUT));
    assign halt_req = active & ~freeze & ~wb_run;

    // State register.
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decision.
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT: state_nxt = S_RUN;
            S_RUN, S_MEM_WAIT: begin
                if (freeze) begin
                    state_nxt = timeout ? S_HALT : S_MEM_WAIT;
                end else if (!wb_run) begin
                    state_nxt = S_HALT;
                end else begin
                    state_nxt = S_RUN;
                end
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_INIT;
        endcase
    end

    // Enables and clears; priority freeze > halt > branch > load-use.
    always_comb begin
        pc_write_en     = 1'b0;
        if_id_write_en  = 1'b0;
        id_ex_write_en  = 1'b0;
        ex_mem_write_en = 1'b0;
        mem_wb_write_en = 1'b0;
        if_id_clear     = 1'b0;
        id_ex_clear     = 1'b0;
        ex_mem_clear    = 1'b0;
        mem_wb_clear    = 1'b0;
        case (state)
            S_INIT: begin
                if_id_clear  = 1'b1;
                id_ex_clear  = 1'b1;
                ex_mem_clear = 1'b1;
                mem_wb_clear = 1'b1;
            end
            S_RUN, S_MEM_WAIT: begin
                if (freeze || !wb_run) begin
                    pc_write_en = 1'b0;
                end else if (ex_branch_taken) begin
                    // Squash IF/ID and ID/EX even when a load-use is present.
                    pc_write_en     = 1'b1;
                    if_id_write_en  = 1'b1;
                    id_ex_write_en  = 1'b1;
                    ex_mem_write_en = 1'b1;
                    mem_wb_write_en = 1'b1;
                    if_id_clear     = 1'b1;
                    id_ex_clear     = 1'b1;
                end else if (load_use) begin
                    // Hold PC and IF/ID, bubble into ID/EX, let the load advance.
                    id_ex_write_en  = 1'b1;
                    ex_mem_write_en = 1'b1;
                    mem_wb_write_en = 1'b1;
                    id_ex_clear     = 1'b1;
                end else begin
                    pc_write_en     = 1'b1;
                    if_id_write_en  = 1'b1;
                    id_ex_write_en  = 1'b1;
                    ex_mem_write_en = 1'b1;
                    mem_wb_write_en = 1'b1;
                end
            end
            default: pc_write_en = 1'b0;
        endcase
    end

    // Wait counter, sticky status flags and saturating stall counter.
    always_ff @(posedge clk) begin
        if (clear) begin
            wcnt         <= '0;
            halted       <= 1'b0;
            mem_error    <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (active && freeze) begin
                wcnt <= wcnt_inc;
            end else begin
                wcnt <= '0;
            end
            if (active && freeze && timeout) begin
                mem_error <= 1'b1;
            end
            if (halt_req) begin
                halted <= 1'b1;
            end
            if (active && !pc_write_en && (stall_cycles != {STALL_W{1'b1}})) begin
                stall_cycles <= stall_cycles + STALL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller with MEM_TIMEOUT=4.
module tb_pipeline_controller;

    logic        clk;
    logic        clear;
    logic [3:0]  id_rs;
    logic [3:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic [3:0]  ex_rd;
    logic        ex_memtoreg;
    logic        ex_branch_taken;
    logic        mem_access;
    logic        mem_ready;
    logic        wb_run;
    logic        pc_write_en;
    logic        if_id_write_en;
    logic        id_ex_write_en;
    logic        ex_mem_write_en;
    logic        mem_wb_write_en;
    logic        if_id_clear;
    logic        id_ex_clear;
    logic        ex_mem_clear;
    logic        mem_wb_clear;
    logic        halted;
    logic        mem_error;
    logic [15:0] stall_cycles;

    logic [4:0]  en;
    logic [3:0]  clr;
    int          n_checks;
    int          n_fails;

    assign en  = {pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en, mem_wb_write_en};
    assign clr = {if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear};

    pipeline_controller #(.MEM_TIMEOUT(4)) dut (
        .clk             (clk),
        .clear           (clear),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_rd           (ex_rd),
        .ex_memtoreg     (ex_memtoreg),
        .ex_branch_taken (ex_branch_taken),
        .mem_access      (mem_access),
        .mem_ready       (mem_ready),
        .wb_run          (wb_run),
        .pc_write_en     (pc_write_en),
        .if_id_write_en  (if_id_write_en),
        .id_ex_write_en  (id_ex_write_en),
        .ex_mem_write_en (ex_mem_write_en),
        .mem_wb_write_en (mem_wb_write_en),
        .if_id_clear     (if_id_clear),
        .id_ex_clear     (id_ex_clear),
        .ex_mem_clear    (ex_mem_clear),
        .mem_wb_clear    (mem_wb_clear),
        .halted          (halted),
        .mem_error       (mem_error),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change at the falling edge; no hazard, no memory access, running.
    task automatic quiet();
        clear           = 1'b0;
        id_rs           = 4'h1;
        id_rt           = 4'h2;
        id_uses_rs      = 1'b0;
        id_uses_rt      = 1'b0;
        ex_rd           = 4'h0;
        ex_memtoreg     = 1'b0;
        ex_branch_taken = 1'b0;
        mem_access      = 1'b0;
        mem_ready       = 1'b0;
        wb_run          = 1'b1;
    endtask

    task automatic load_use_rs();
        ex_memtoreg = 1'b1;
        ex_rd       = 4'h3;
        id_rs       = 4'h3;
        id_uses_rs  = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk); quiet(); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        #1;
        check("rst_init_clr", 32'(clr), 32'hF);
        check("rst_init_en", 32'(en), 32'h0);
        @(negedge clk); #1;
        check("rst_run_en", 32'(en), 32'h1F);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        quiet();
        clear = 1'b1;

        // Reset held for two edges, then released.
        @(negedge clk); #1;
        check("clear_held_clr", 32'(clr), 32'hF);
        check("clear_held_en", 32'(en), 32'h0);
        @(negedge clk); clear = 1'b0; #1;
        check("rel_clr", 32'(clr), 32'hF);
        check("rel_en", 32'(en), 32'h0);
        check("rel_halted", 32'(halted), 32'h0);
        check("rel_mem_error", 32'(mem_error), 32'h0);
        check("rel_stall", 32'(stall_cycles), 32'h0);
        @(negedge clk); #1;
        check("run_en", 32'(en), 32'h1F);
        check("run_clr", 32'(clr), 32'h0);
        check("run_stall", 32'(stall_cycles), 32'h0);

        // Load-use on rs.
        @(negedge clk); load_use_rs(); #1;
        check("lu_en_masked", 32'(en & 5'b11011), 32'h03);
        check("lu_clr", 32'(clr), 32'h4);
        @(negedge clk); id_uses_rs = 1'b0; #1;
        check("lu_stall", 32'(stall_cycles), 32'h1);
        check("nolu_en", 32'(en), 32'h1F);
        check("nolu_clr", 32'(clr), 32'h0);
        // Load-use on rt.
        @(negedge clk); id_rt = 4'h3; id_uses_rt = 1'b1; #1;
        check("nolu_stall", 32'(stall_cycles), 32'h1);
        check("lu_rt_en_masked", 32'(en & 5'b11011), 32'h03);

        // Branch together with load-use: branch wins, no stall.
        @(negedge clk); quiet(); load_use_rs(); ex_branch_taken = 1'b1; #1;
        check("br_lu_en", 32'(en), 32'h1F);
        check("br_lu_clr", 32'(clr), 32'hC);
        @(negedge clk); quiet(); #1;
        check("br_lu_stall", 32'(stall_cycles), 32'h2);

        // Three-cycle memory wait; the last frozen cycle also carries a branch.
        @(negedge clk); mem_access = 1'b1; mem_ready = 1'b0; #1;
        check("mw1_en", 32'(en), 32'h0);
        check("mw1_clr", 32'(clr), 32'h0);
        @(negedge clk); #1;
        check("mw2_en", 32'(en), 32'h0);
        @(negedge clk); ex_branch_taken = 1'b1; #1;
        check("mw3_br_en", 32'(en), 32'h0);
        check("mw3_br_clr", 32'(clr), 32'h0);
        @(negedge clk); ex_branch_taken = 1'b0; mem_ready = 1'b1; #1;
        check("mw_ready_en", 32'(en), 32'h1F);
        check("mw_stall", 32'(stall_cycles), 32'h5);
        check("mw_no_err", 32'(mem_error), 32'h0);
        @(negedge clk); quiet(); #1;
        check("mw_back_run_en", 32'(en), 32'h1F);
        check("mw_back_stall", 32'(stall_cycles), 32'h5);

        // Timeout after four frozen cycles.
        @(negedge clk); mem_access = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); #1;
        check("to_3_no_err", 32'(mem_error), 32'h0);
        check("to_4_en", 32'(en), 32'h0);
        @(negedge clk); #1;
        check("to_err", 32'(mem_error), 32'h1);
        check("to_halted", 32'(halted), 32'h0);
        check("to_en", 32'(en), 32'h0);
        check("to_stall", 32'(stall_cycles), 32'h9);
        @(negedge clk); quiet(); #1;
        check("to_sticky_en", 32'(en), 32'h0);
        check("to_sticky_stall", 32'(stall_cycles), 32'h9);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0; #1;
        check("to_clr_err", 32'(mem_error), 32'h0);
        check("to_clr_stall", 32'(stall_cycles), 32'h0);
        check("to_clr_init", 32'(clr), 32'hF);
        @(negedge clk); #1;
        check("to_clr_run_en", 32'(en), 32'h1F);

        // Halt from WB.
        @(negedge clk); wb_run = 1'b0; #1;
        check("halt_en", 32'(en), 32'h0);
        check("halt_clr", 32'(clr), 32'h0);
        check("halt_pre", 32'(halted), 32'h0);
        @(negedge clk); wb_run = 1'b1; #1;
        check("halt_set", 32'(halted), 32'h1);
        check("halt_en_after", 32'(en), 32'h0);
        check("halt_stall", 32'(stall_cycles), 32'h1);
        @(negedge clk); #1;
        check("halt_sticky", 32'(halted), 32'h1);
        check("halt_stall_frozen", 32'(stall_cycles), 32'h1);
        do_reset();
        check("halt_cleared", 32'(halted), 32'h0);

        // Saturation: a held load-use stalls every cycle.
        @(negedge clk); load_use_rs();
        for (int i = 0; i < 65540; i++) begin
            @(negedge clk);
        end
        #1;
        check("sat_value", 32'(stall_cycles), 32'hFFFF);
        check("sat_en_masked", 32'(en & 5'b11011), 32'h03);
        @(negedge clk); #1;
        check("sat_no_wrap", 32'(stall_cycles), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
